bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_beat_counter.sv | 50 +++++
 rtl/bus_arbiter.sv | 125 ++++++++++++
 tb/tb_bus_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-requester bus arbiter.
//   DEF_WIDTH      : default payload width of each requester and of bus_data
//   DEF_MAX_BEATS  : default beat quota a requester keeps while the other waits
//   state_e        : arbiter FSM states (IDLE, OWN0, OWN1)
//   own_state()    : maps a requester index to its ownership state
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    function automatic state_e own_state(input logic who);
        return who ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// -----------------------------------------------------------------------------
// bus_beat_counter
// Counts beats of the current bus tenure. Never counts past MAX_BEATS-1; the
// owner of the counter is expected to clear it at terminal count.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-low reset
//   inc_i  : a beat happened this cycle
//   clr_i  : clear to zero (takes priority over inc_i)
//   tc_o   : count equals MAX_BEATS-1
// -----------------------------------------------------------------------------
module bus_beat_counter
    import bus_pkg::*;
#(
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_BEATS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            // Saturate rather than wrap if a caller forgets to clear.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-requester bus arbiter with a per-tenure beat quota. A requester keeps
// the bus while it requests; once it has taken MAX_BEATS beats and the other
// side is waiting, ownership hands over with no idle cycle. Uncontended
// owners hold indefinitely. Ties from IDLE go to the requester that did not
// win last (requester 0 after reset).
// Ports:
//   clk       : clock
//   reset     : synchronous, active-low reset
//   req_0/1   : level-sensitive bus requests
//   data_0/1  : requester payloads
//   gnt_0/1   : requester owns the bus this cycle
//   bus_sel   : datapath mux select (1 = requester 1)
//   bus_data  : registered payload of the last beat
//   bus_valid : bus_data was transferred in the previous cycle
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic [WIDTH-1:0] data_0,
    input  logic             req_1,
    input  logic [WIDTH-1:0] data_1,
    output logic             gnt_0,
    output logic             gnt_1,
    output logic             bus_sel,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid
);

    state_e           state_q, state_d;
    logic             last_winner_q, last_winner_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             bus_valid_q, bus_valid_d;

    logic             owner;      // index of the current owner (0 in IDLE)
    logic             own_req;
    logic             other_req;
    logic [WIDTH-1:0] own_data;
    logic             beat;
    logic             tc;
    logic             cnt_clr;

    bus_beat_counter #(
        .MAX_BEATS(MAX_BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (beat),
        .clr_i (cnt_clr),
        .tc_o  (tc)
    );

    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        beat          = 1'b0;
        owner         = (state_q == OWN1);
        own_req       = owner ? req_1 : req_0;
        other_req     = owner ? req_0 : req_1;
        own_data      = owner ? data_1 : data_0;

        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    state_d = own_state(~last_winner_q);
                end else if (req_0) begin
                    state_d = OWN0;
                end else if (req_1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (own_req) begin
                    beat = 1'b1;
                    // Quota exhausted only matters when someone is waiting.
                    if (tc && other_req) begin
                        state_d = own_state(~owner);
                    end
                end else if (other_req) begin
                    state_d = own_state(~owner);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) && (state_d != IDLE)) begin
            last_winner_d = (state_d == OWN1);
        end

        // A terminal-count beat that keeps ownership starts a fresh quota.
        cnt_clr     = (state_d != state_q) || (beat && tc);
        bus_valid_d = beat;
        bus_data_d  = beat ? own_data : bus_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_winner_q <= 1'b1;
            bus_data_q    <= '0;
            bus_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            bus_data_q    <= bus_data_d;
            bus_valid_q   <= bus_valid_d;
        end
    end

    assign gnt_0     = (state_q == OWN0);
    assign gnt_1     = (state_q == OWN1);
    assign bus_sel   = (state_q == OWN1);
    assign bus_data  = bus_data_q;
    assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Scoreboard bench: the driver applies one input set per cycle, advances a
// behavioural model of the arbitration rules and queues the outputs expected
// after the next clock edge. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int W  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_0 = 1'b0;
    logic         req_1 = 1'b0;
    logic [W-1:0] data_0 = '0;
    logic [W-1:0] data_1 = '0;
    logic         gnt_0, gnt_1, bus_sel, bus_valid;
    logic [W-1:0] bus_data;

    bus_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .data_0    (data_0),
        .req_1     (req_1),
        .data_1    (data_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .bus_sel   (bus_sel),
        .bus_data  (bus_data),
        .bus_valid (bus_valid)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int           cyc;
        logic         g0;
        logic         g1;
        logic         sel;
        logic         v;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: who owns the bus (-1 = nobody), beats taken in the
    // current quota window, who won last, and the visible data register.
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_last  = 1;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;

    task automatic model_step(input logic rst, input logic r0, input logic [W-1:0] d0,
                              input logic r1, input logic [W-1:0] d1);
        logic         rq[2];
        logic [W-1:0] dt[2];
        int           x, y;
        rq[0] = r0; rq[1] = r1;
        dt[0] = d0; dt[1] = d1;
        if (!rst) begin
            m_owner = -1; m_held = 0; m_last = 1; m_valid = 1'b0; m_data = '0;
            return;
        end
        m_valid = 1'b0;
        if (m_owner < 0) begin
            if (r0 && r1)  m_owner = 1 - m_last;
            else if (r0)   m_owner = 0;
            else if (r1)   m_owner = 1;
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 0;
            end
        end else begin
            x = m_owner;
            y = 1 - x;
            if (rq[x]) begin
                m_valid = 1'b1;
                m_data  = dt[x];
                m_held++;
                if (m_held == MB) begin
                    m_held = 0;
                    if (rq[y]) begin
                        m_owner = y;
                        m_last  = y;
                    end
                end
            end else if (rq[y]) begin
                m_owner = y; m_last = y; m_held = 0;
            end else begin
                m_owner = -1; m_held = 0;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic [W-1:0] d0,
                         input logic r1, input logic [W-1:0] d1);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        req_0  = r0;
        data_0 = d0;
        req_1  = r1;
        data_1 = d1;
        model_step(rst, r0, d0, r1, d1);
        e.cyc = cyc_cnt + 1;
        e.g0  = (m_owner == 0);
        e.g1  = (m_owner == 1);
        e.sel = (m_owner == 1);
        e.v   = m_valid;
        e.d   = m_data;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the outputs visible after each edge with the entry
    // predicted for that edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            e = exp_q.pop_front();
            n_miss++;
            $display("FAIL stale: expectation for cycle %0d never checked (now %0d)", e.cyc, cyc_cnt);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            n_vec++;
            if (gnt_0 !== e.g0 || gnt_1 !== e.g1 || bus_sel !== e.sel ||
                bus_valid !== e.v || bus_data !== e.d) begin
                n_miss++;
                $display("FAIL vec cyc %0d: got g0=%b g1=%b sel=%b v=%b d=%h, want g0=%b g1=%b sel=%b v=%b d=%h",
                         cyc_cnt, gnt_0, gnt_1, bus_sel, bus_valid, bus_data,
                         e.g0, e.g1, e.sel, e.v, e.d);
            end else begin
                $display("cyc %0d: g0=%b g1=%b sel=%b v=%b d=%h ok",
                         cyc_cnt, gnt_0, gnt_1, bus_sel, bus_valid, bus_data);
            end
        end
    end

    initial begin
        logic         r0, r1, rs;
        logic [W-1:0] d0, d1;

        // Reset held two cycles with req_0 high, then released.
        drive(1'b0, 1'b1, 4'h3, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 4'h3, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 4'h3, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h3, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // First tie after reset goes to requester 0; data 4'hA.
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'hA, 1'b1, 4'h6);

        // Both held 16+ cycles: 4/4 alternation with changing payloads.
        for (int i = 0; i < 18; i++)
            drive(1'b1, 1'b1, W'(i), 1'b1, W'(15 - i));
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Requester 1 alone for 10 cycles with data 4'h5.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h5);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // req_0 drops after 2 beats with req_1 pending, then returns so the
        // new owner's full quota of 4 beats is observable.
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 4'h1, 1'b1, 4'h2);
        drive(1'b1, 1'b1, 4'h1, 1'b1, 4'h2);
        drive(1'b1, 1'b1, 4'h1, 1'b1, 4'h2);
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h2);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 4'h7, 1'b1, W'(i + 8));
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Reset during requester 1's second beat, then a tie.
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'hC);
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'hC);
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'hD);
        drive(1'b1, 1'b1, 4'h9, 1'b1, 4'hE);
        drive(1'b1, 1'b1, 4'h9, 1'b1, 4'hE);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Randomized traffic with persistent requests and rare resets.
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            rs = ($urandom_range(49) != 0);
            d0 = W'($urandom);
            d1 = W'($urandom);
            drive(rs, r0, d0, r1, d1);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
